// File: rtl/ddr_lane_judge_pkg.sv
// Shared definitions for the lane judge: lane indices, default geometry,
// scoring defaults and the play-state encoding the game FSM uses to derive run.
package ddr_lane_judge_pkg;

    localparam int LANE_LEFT  = 0;
    localparam int LANE_DOWN  = 1;
    localparam int LANE_UP    = 2;
    localparam int LANE_RIGHT = 3;

    localparam int DEF_NUM_LANES = 4;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_MULT_STEP = 10;
    localparam int DEF_MAX_MULT  = 8;

    typedef enum logic [1:0] {
        PS_MENU  = 2'd0,
        PS_PLAY  = 2'd1,
        PS_PAUSE = 2'd2,
        PS_OVER  = 2'd3
    } play_state_e;

    function automatic logic play_state_runs(play_state_e s);
        return s == PS_PLAY;
    endfunction

endpackage

// File: rtl/ddr_lane_judge_streak.sv
// Combo / multiplier / life bookkeeping driven by the judgement events.
// Written as a separate file so the top stays focused on field and judgement.
module ddr_streak_counter
    import ddr_lane_judge_pkg::*;
#(
    parameter int COMBO_W   = 14,
    parameter int MULT_STEP = DEF_MULT_STEP,
    parameter int MAX_MULT  = DEF_MAX_MULT,
    parameter int LIFE_INIT = 4,
    parameter int LIFE_W    = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_correct,
    input  logic               i_incorrect,
    input  logic               i_miss,
    output logic [COMBO_W-1:0] o_combo,
    output logic [3:0]         o_mult,
    output logic [LIFE_W-1:0]  o_life,
    output logic               o_game_over
);
    localparam int STEP_W = (MULT_STEP > 1) ? $clog2(MULT_STEP) : 1;

    logic [COMBO_W-1:0] r_combo;
    logic [STEP_W-1:0]  r_step;
    logic [3:0]         r_mult;
    logic [LIFE_W-1:0]  r_life;
    logic               r_game_over;
    logic               w_bad;

    assign w_bad = i_incorrect | i_miss;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_combo     <= '0;
            r_step      <= '0;
            r_mult      <= 4'd1;
            r_life      <= LIFE_W'(LIFE_INIT);
            r_game_over <= 1'b0;
        end else if (!r_game_over) begin
            // A bad event costs one life even when wrong press and miss coincide
            if (w_bad) begin
                r_combo <= '0;
                r_step  <= '0;
                r_mult  <= 4'd1;
                if (r_life != '0) begin
                    r_life <= r_life - 1'b1;
                    if (r_life == LIFE_W'(1))
                        r_game_over <= 1'b1;
                end
            end else if (i_correct) begin
                if (r_combo != '1)
                    r_combo <= r_combo + 1'b1;
                if (r_step == STEP_W'(MULT_STEP - 1)) begin
                    r_step <= '0;
                    if (r_mult < 4'(MAX_MULT))
                        r_mult <= r_mult + 1'b1;
                end else begin
                    r_step <= r_step + 1'b1;
                end
            end
        end
    end

    assign o_combo     = r_combo;
    assign o_mult      = r_mult;
    assign o_life      = r_life;
    assign o_game_over = r_game_over;

endmodule

// File: rtl/ddr_lane_judge.sv
// Scrolling note field, button edge detect and hit judgement for NUM_LANES
// lanes; scoring state lives in ddr_streak_counter.
module ddr_lane_judge
    import ddr_lane_judge_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int COMBO_W   = 14,
    parameter int MULT_STEP = DEF_MULT_STEP,
    parameter int MAX_MULT  = DEF_MAX_MULT,
    parameter int LIFE_INIT = 4,
    parameter int LIFE_W    = 3
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       beat,
    input  logic                       run,
    input  logic [NUM_LANES-1:0]       next_arrow,
    input  logic [NUM_LANES-1:0]       btn,
    output logic [DEPTH*NUM_LANES-1:0] rows,
    output logic                       correct_hit,
    output logic                       incorrect_hit,
    output logic                       miss,
    output logic [COMBO_W-1:0]         combo,
    output logic [3:0]                 multiplier,
    output logic [LIFE_W-1:0]          life,
    output logic                       game_over
);
    logic [DEPTH-1:0][NUM_LANES-1:0] r_rows;
    logic [NUM_LANES-1:0] r_btn_q, r_acc;
    logic                 r_judged, r_cor, r_inc, r_miss;
    logic [NUM_LANES-1:0] w_press, w_hit, w_acc_nx;
    logic                 w_judged_nx, w_cor, w_inc, w_miss, w_active, w_shift;

    assign w_active = run & ~game_over;
    assign w_press  = btn & ~r_btn_q;
    assign w_hit    = r_rows[DEPTH-1];
    assign w_shift  = w_active & beat;

    always_comb begin
        w_cor       = 1'b0;
        w_inc       = 1'b0;
        w_acc_nx    = r_acc;
        w_judged_nx = r_judged;
        if (w_active && w_press != '0) begin
            if (w_hit == '0 || r_judged) begin
                w_inc = 1'b1;
            end else if ((w_press & ~w_hit) != '0) begin
                w_inc    = 1'b1;
                w_acc_nx = '0;
            end else if ((r_acc | w_press) == w_hit) begin
                w_cor       = 1'b1;
                w_judged_nx = 1'b1;
                w_acc_nx    = '0;
            end else begin
                w_acc_nx = r_acc | w_press;
            end
        end
        // Miss sees the judged state after any same-cycle press
        w_miss = w_shift && (w_hit != '0) && !w_judged_nx;
        if (w_shift) begin
            w_judged_nx = 1'b0;
            w_acc_nx    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rows   <= '0;
            r_btn_q  <= '0;
            r_acc    <= '0;
            r_judged <= 1'b0;
            r_cor    <= 1'b0;
            r_inc    <= 1'b0;
            r_miss   <= 1'b0;
        end else begin
            r_btn_q  <= btn;
            r_acc    <= w_acc_nx;
            r_judged <= w_judged_nx;
            r_cor    <= w_cor;
            r_inc    <= w_inc;
            r_miss   <= w_miss;
            if (w_shift)
                r_rows <= {r_rows[DEPTH-2:0], next_arrow};
        end
    end

    ddr_streak_counter #(
        .COMBO_W   (COMBO_W),
        .MULT_STEP (MULT_STEP),
        .MAX_MULT  (MAX_MULT),
        .LIFE_INIT (LIFE_INIT),
        .LIFE_W    (LIFE_W)
    ) u_streak (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_correct   (w_cor),
        .i_incorrect (w_inc),
        .i_miss      (w_miss),
        .o_combo     (combo),
        .o_mult      (multiplier),
        .o_life      (life),
        .o_game_over (game_over)
    );

    assign rows          = r_rows;
    assign correct_hit   = r_cor;
    assign incorrect_hit = r_inc;
    assign miss          = r_miss;

endmodule

// File: tb/tb_ddr_lane_judge.sv
// Directed bench for ddr_lane_judge: a vector table of per-cycle stimulus with
// hand-computed outputs, plus hand sequences for multiplier, game over, pause and reset.
module tb_ddr_lane_judge;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        beat = 1'b0;
    logic        run = 1'b1;
    logic [3:0]  next_arrow = '0;
    logic [3:0]  btn = '0;
    logic [15:0] rows;
    logic        correct_hit, incorrect_hit, miss;
    logic [13:0] combo;
    logic [3:0]  multiplier;
    logic [2:0]  life;
    logic        game_over;

    int errors = 0;
    int checks = 0;

    ddr_lane_judge dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .beat          (beat),
        .run           (run),
        .next_arrow    (next_arrow),
        .btn           (btn),
        .rows          (rows),
        .correct_hit   (correct_hit),
        .incorrect_hit (incorrect_hit),
        .miss          (miss),
        .combo         (combo),
        .multiplier    (multiplier),
        .life          (life),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        b;
        logic [3:0]  a;
        logic [3:0]  bt;
        logic [2:0]  pul;   // {correct, incorrect, miss}
        logic [13:0] combo;
        logic [3:0]  mult;
        logic [2:0]  life;
        logic        go;
        logic [15:0] rows;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rst, logic b, logic [3:0] a, logic [3:0] bt,
                                logic [2:0] pul, int cmb, int mlt, int lf,
                                logic go, logic [15:0] rw);
        vec_t v;
        v.rst = rst; v.b = b; v.a = a; v.bt = bt; v.pul = pul;
        v.combo = 14'(cmb); v.mult = 4'(mlt); v.life = 3'(lf); v.go = go; v.rows = rw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic b, input logic [3:0] a, input logic [3:0] bt);
        beat = b; next_arrow = a; btn = bt;
        @(posedge clk); #1;
        beat = 1'b0;
    endtask

    task automatic do_reset();
        btn = '0; beat = 1'b0; run = 1'b1;
        reset_n = 1'b0; #3; reset_n = 1'b1;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] pul, input int cmb,
                           input int mlt, input int lf, input logic go, input logic [15:0] rw);
        chk({tag, " pulses"}, {29'd0, correct_hit, incorrect_hit, miss}, {29'd0, pul});
        chk({tag, " combo"}, 32'(combo), 32'(cmb));
        chk({tag, " mult"}, 32'(multiplier), 32'(mlt));
        chk({tag, " life"}, 32'(life), 32'(lf));
        chk({tag, " game_over"}, 32'(game_over), 32'(go));
        chk({tag, " rows"}, 32'(rows), 32'(rw));
    endtask

    initial begin
        // Table: beats/no-press miss, single hit + re-press, chord with wrong lane,
        // then after reset: split chord, press on beat, wrong press + miss together.
        tv.push_back(mk(1,1,4'h1,4'h0,3'b000,0,1,4,0,16'h0001));
        tv.push_back(mk(0,1,4'h1,4'h0,3'b000,0,1,4,0,16'h0011));
        tv.push_back(mk(0,1,4'h1,4'h0,3'b000,0,1,4,0,16'h0111));
        tv.push_back(mk(0,1,4'h1,4'h0,3'b000,0,1,4,0,16'h1111));
        tv.push_back(mk(0,1,4'h0,4'h0,3'b001,0,1,3,0,16'h1110));
        tv.push_back(mk(0,0,4'h0,4'h1,3'b100,1,1,3,0,16'h1110));
        tv.push_back(mk(0,1,4'h4,4'h1,3'b000,1,1,3,0,16'h1104));
        tv.push_back(mk(0,0,4'h0,4'h0,3'b000,1,1,3,0,16'h1104));
        tv.push_back(mk(0,0,4'h0,4'h1,3'b100,2,1,3,0,16'h1104));
        tv.push_back(mk(0,1,4'h9,4'h0,3'b000,2,1,3,0,16'h1049));
        tv.push_back(mk(0,0,4'h0,4'h1,3'b100,3,1,3,0,16'h1049));
        tv.push_back(mk(0,1,4'h0,4'h0,3'b000,3,1,3,0,16'h0490));
        tv.push_back(mk(0,1,4'h0,4'h0,3'b000,3,1,3,0,16'h4900));
        tv.push_back(mk(0,0,4'h0,4'h4,3'b100,4,1,3,0,16'h4900));
        tv.push_back(mk(0,0,4'h0,4'h4,3'b000,4,1,3,0,16'h4900));
        tv.push_back(mk(0,0,4'h0,4'h0,3'b000,4,1,3,0,16'h4900));
        tv.push_back(mk(0,0,4'h0,4'h4,3'b010,0,1,2,0,16'h4900));
        tv.push_back(mk(0,1,4'h0,4'h0,3'b000,0,1,2,0,16'h9000));
        tv.push_back(mk(0,0,4'h0,4'h1,3'b000,0,1,2,0,16'h9000));
        tv.push_back(mk(0,0,4'h0,4'h3,3'b010,0,1,1,0,16'h9000));
        tv.push_back(mk(0,0,4'h0,4'hb,3'b000,0,1,1,0,16'h9000));
        tv.push_back(mk(0,0,4'h0,4'h0,3'b000,0,1,1,0,16'h9000));
        tv.push_back(mk(0,0,4'h0,4'h9,3'b100,1,1,1,0,16'h9000));
        tv.push_back(mk(1,1,4'h9,4'h0,3'b000,0,1,4,0,16'h0009));
        tv.push_back(mk(0,1,4'h2,4'h0,3'b000,0,1,4,0,16'h0092));
        tv.push_back(mk(0,1,4'h4,4'h0,3'b000,0,1,4,0,16'h0924));
        tv.push_back(mk(0,1,4'h0,4'h0,3'b000,0,1,4,0,16'h9240));
        tv.push_back(mk(0,0,4'h0,4'h1,3'b000,0,1,4,0,16'h9240));
        tv.push_back(mk(0,0,4'h0,4'h1,3'b000,0,1,4,0,16'h9240));
        tv.push_back(mk(0,0,4'h0,4'h9,3'b100,1,1,4,0,16'h9240));
        tv.push_back(mk(0,0,4'h0,4'h9,3'b000,1,1,4,0,16'h9240));
        tv.push_back(mk(0,1,4'h0,4'h0,3'b000,1,1,4,0,16'h2400));
        tv.push_back(mk(0,1,4'h0,4'h2,3'b100,2,1,4,0,16'h4000));
        tv.push_back(mk(0,0,4'h0,4'h0,3'b000,2,1,4,0,16'h4000));
        tv.push_back(mk(0,1,4'h0,4'h1,3'b011,0,1,3,0,16'h0000));
        tv.push_back(mk(0,0,4'h0,4'h0,3'b000,0,1,3,0,16'h0000));

        // Reset state
        #12;
        chk_all("reset", 3'b000, 0, 1, 4, 1'b0, 16'h0000);
        @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (tv[i]) begin
            if (tv[i].rst) do_reset();
            cyc(tv[i].b, tv[i].a, tv[i].bt);
            chk_all($sformatf("v%0d", i), tv[i].pul, int'(tv[i].combo), int'(tv[i].mult),
                    int'(tv[i].life), tv[i].go, tv[i].rows);
        end

        // Twenty straight hits: multiplier steps at 10 and 20, a miss resets it
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, 4'h1, 4'h0);
        for (int h = 1; h <= 20; h++) begin
            cyc(1'b0, 4'h0, 4'h1);
            chk($sformatf("hit%0d cor", h), 32'(correct_hit), 32'd1);
            chk($sformatf("hit%0d combo", h), 32'(combo), 32'(h));
            chk($sformatf("hit%0d mult", h), 32'(multiplier), (h >= 20) ? 32'd3 : (h >= 10) ? 32'd2 : 32'd1);
            cyc(1'b1, 4'h1, 4'h0);
            chk($sformatf("hit%0d nomiss", h), 32'(miss), 32'd0);
        end
        cyc(1'b1, 4'h1, 4'h0);
        chk_all("mult_miss", 3'b001, 0, 1, 3, 1'b0, 16'h1111);

        // Four misses exhaust lives; field and counters then freeze
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, 4'h1, 4'h0);
        for (int m = 1; m <= 4; m++) begin
            cyc(1'b1, 4'h1, 4'h0);
            chk($sformatf("gomiss%0d life", m), 32'(life), 32'(4 - m));
            chk($sformatf("gomiss%0d go", m), 32'(game_over), (m == 4) ? 32'd1 : 32'd0);
        end
        cyc(1'b1, 4'h2, 4'h0);
        chk_all("frozen_beat", 3'b000, 0, 1, 0, 1'b1, 16'h1111);
        cyc(1'b0, 4'h0, 4'h1);
        chk_all("frozen_press", 3'b000, 0, 1, 0, 1'b1, 16'h1111);

        // Button held across pause/resume never produces an event
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1'b1, 4'h4, 4'h0);
        run = 1'b0;
        cyc(1'b1, 4'h2, 4'h4);
        chk_all("pause1", 3'b000, 0, 1, 4, 1'b0, 16'h4444);
        cyc(1'b1, 4'h2, 4'h4);
        chk_all("pause2", 3'b000, 0, 1, 4, 1'b0, 16'h4444);
        run = 1'b1;
        cyc(1'b0, 4'h0, 4'h4);
        chk_all("resume_held", 3'b000, 0, 1, 4, 1'b0, 16'h4444);
        cyc(1'b0, 4'h0, 4'h0);
        cyc(1'b0, 4'h0, 4'h4);
        chk_all("resume_press", 3'b100, 1, 1, 4, 1'b0, 16'h4444);

        // Asynchronous reset between edges clears everything at once
        reset_n = 1'b0;
        #1;
        chk_all("async_rst", 3'b000, 0, 1, 4, 1'b0, 16'h0000);
        #2;
        reset_n = 1'b1;
        btn = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
